// File: rtl/suna_pkg.sv
// Shared definitions for the alarm sequencer: FSM state encoding and default parameters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package suna_pkg;

  // Legacy-compatible state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RING_ON  = 2'd1;
  localparam state_t ST_RING_OFF = 2'd2;
  localparam state_t ST_COOLDOWN = 2'd3;

  // Production defaults
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TICK_DIV    = 25_000_000;
  localparam int DEF_RING_CYCLES = 10;
  localparam int DEF_GAP_TICKS   = 50_000_000;

endpackage

// File: rtl/suna_ctrl_if.sv
// Request/ring bundle between timer/button logic (master) and the alarm sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: none; requests are levels, dismiss is a single-cycle pulse.
interface suna_ctrl_if
  import suna_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);
  logic [N_REQ-1:0]         req;
  logic                     dismiss;
  logic                     ring;
  logic                     active;
  logic [N_REQ-1:0]         grant;
  logic [$clog2(N_REQ)-1:0] owner;

  modport master (output req, output dismiss, input ring, input active, input grant, input owner);
  modport slave  (input req, input dismiss, output ring, output active, output grant, output owner);
endinterface

// File: rtl/suna_rr_arbiter.sv
// Round-robin pick among pending alarm sources, searching from the source after the last winner.
// Latency: purely combinational.
// Backpressure: none; result is only consumed when the sequencer is idle.
module suna_rr_arbiter
  import suna_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         pending,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         win_onehot,
  output logic [$clog2(N_REQ)-1:0] win_idx,
  output logic                     win_vld
);

  // First pending source at offsets 1..N_REQ from last; last itself is checked last
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_vld && pending[(int'(last) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = ($clog2(N_REQ))'((int'(last) + k) % N_REQ);
        win_onehot[(int'(last) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/suna_ctrl.sv
// Alarm sequencer: latches request edges, serves sources round-robin with an on/off ring cadence, then a quiet gap.
// Latency: req rise sampled at edge k -> ring/active/grant high after edge k+1 when idle.
// Backpressure: none; requests arriving mid-event stay pending until the sequencer returns to idle.
module suna_ctrl
  import suna_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int RING_CYCLES = DEF_RING_CYCLES,
  parameter int GAP_TICKS   = DEF_GAP_TICKS
) (
  input logic        clock,
  input logic        reset,
  suna_ctrl_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(TICK_DIV);
  localparam int PW = $clog2(RING_CYCLES + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  localparam logic [HW-1:0] HALF_LOAD = HW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PER_LOAD  = PW'(RING_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  state_t           state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] clr_mask;
  logic [IW-1:0]    last;
  logic [IW-1:0]    owner_r;
  logic [N_REQ-1:0] grant_r;
  logic             ring_r;
  logic             active_r;
  logic [HW-1:0]    half_cnt;
  logic [PW-1:0]    per_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [N_REQ-1:0] arb_win;
  logic [IW-1:0]    arb_idx;
  logic             arb_vld;
  logic             in_ring;
  logic             half_done;
  logic             ev_end;

  assign rise      = bus.req & ~req_q;
  assign in_ring   = (state == ST_RING_ON) || (state == ST_RING_OFF);
  assign half_done = (half_cnt == '0);
  // An event ends on dismiss, or when the last off half-period of the last cycle expires
  assign ev_end    = (in_ring && bus.dismiss) ||
                     ((state == ST_RING_OFF) && half_done && (per_cnt == PW'(1)));
  // grant_r is the one-hot of owner during an event, so it doubles as the clear mask
  assign clr_mask  = ev_end ? grant_r : '0;

  assign bus.ring   = ring_r;
  assign bus.active = active_r;
  assign bus.grant  = grant_r;
  assign bus.owner  = owner_r;

  suna_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .pending    (pending),
    .last       (last),
    .win_onehot (arb_win),
    .win_idx    (arb_idx),
    .win_vld    (arb_vld)
  );

  // Request edge detect and pending flags; a new rise beats a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q   <= bus.req;
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  // Sequencer FSM with cadence/gap counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ring_r   <= 1'b0;
      active_r <= 1'b0;
      grant_r  <= '0;
      owner_r  <= '0;
      last     <= LAST_INIT;
      half_cnt <= '0;
      per_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            state    <= ST_RING_ON;
            ring_r   <= 1'b1;
            active_r <= 1'b1;
            grant_r  <= arb_win;
            owner_r  <= arb_idx;
            last     <= arb_idx;
            half_cnt <= HALF_LOAD;
            per_cnt  <= PER_LOAD;
          end
        end
        ST_RING_ON, ST_RING_OFF: begin
          if (ev_end) begin
            state    <= ST_COOLDOWN;
            ring_r   <= 1'b0;
            active_r <= 1'b0;
            grant_r  <= '0;
            gap_cnt  <= GAP_LOAD;
          end else if (half_done) begin
            half_cnt <= HALF_LOAD;
            if (state == ST_RING_ON) begin
              state  <= ST_RING_OFF;
              ring_r <= 1'b0;
            end else begin
              state   <= ST_RING_ON;
              ring_r  <= 1'b1;
              per_cnt <= per_cnt - PW'(1);
            end
          end else begin
            half_cnt <= half_cnt - HW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_suna_ctrl.sv
// Scoreboard bench for suna_ctrl: stimulus queues expected ring events, a monitor checks them as they appear.
// Small parameters (TICK_DIV=4, RING_CYCLES=2, GAP_TICKS=3) keep every event a few tens of cycles long.
module tb_suna_ctrl;
  localparam int N_REQ       = 4;
  localparam int TICK_DIV    = 4;
  localparam int RING_CYCLES = 2;
  localparam int GAP_TICKS   = 3;
  localparam int EV_LEN      = 2 * TICK_DIV * RING_CYCLES;
  localparam int SPACING     = EV_LEN + GAP_TICKS + 1;

  typedef struct {
    int cyc;
    int gnt;
    int own;
    int len;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  suna_ctrl_if #(.N_REQ(N_REQ)) bus ();

  suna_ctrl #(
    .N_REQ(N_REQ), .TICK_DIV(TICK_DIV), .RING_CYCLES(RING_CYCLES), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int g, input int o, input int l);
    exp_t e;
    e.cyc = c; e.gnt = g; e.own = o; e.len = l;
    q.push_back(e);
  endtask

  // Advance to the falling edge at which cyc == k
  task automatic goto(input int k);
    while (cyc < k) @(negedge clock);
  endtask

  // Monitor: sampled 2 time units after each rising edge
  logic prev_ring = 1'b0;
  logic prev_act  = 1'b0;
  int   hi_len    = 0;
  int   act_cnt   = 0;
  int   cur_len   = -1;
  exp_t me;

  always begin
    @(posedge clock);
    #2;
    if (reset) begin
      prev_ring = 1'b0;
      prev_act  = 1'b0;
    end else begin
      if (bus.ring && !prev_ring) begin
        if (!prev_act) begin
          if (q.size() == 0) begin
            chk("unexpected_ring_start", cyc, -1);
            cur_len = -1;
          end else begin
            me = q.pop_front();
            chk("start_cycle", cyc, me.cyc);
            chk("grant", int'(bus.grant), me.gnt);
            chk("owner", int'(bus.owner), me.own);
            cur_len = me.len;
          end
          act_cnt = 0;
        end
        hi_len = 1;
      end else if (bus.ring) begin
        hi_len++;
      end
      if (!bus.ring && prev_ring) chk("ring_high_len", hi_len, TICK_DIV);
      if (bus.active) act_cnt++;
      if (!bus.active && prev_act && cur_len >= 0) chk("active_len", act_cnt, cur_len);
      prev_ring = bus.ring;
      prev_act  = bus.active;
    end
  end

  int b, s1, s3, s, s5, r;

  initial begin
    bus.req     = 4'b1001;
    bus.dismiss = 1'b0;

    // Reset state, with req[0] and req[3] already high
    repeat (3) @(negedge clock);
    #1;
    chk("reset_ring", int'(bus.ring), 0);
    chk("reset_active", int'(bus.active), 0);
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_owner", int'(bus.owner), 0);

    // Requests held through reset count as edges; source 0 goes first
    @(negedge clock);
    b = cyc;
    reset = 1'b0;
    push(b + 2, 4'b0001, 0, EV_LEN);
    push(b + 2 + SPACING, 4'b1000, 3, EV_LEN);
    goto(b + 3);
    bus.req = 4'b0000;

    // After source 1, pending {0,1,3} is served 3, 0, 1; then a re-raise on timeout repeats source 1
    goto(b + 2 + 2 * SPACING + 2);
    b  = cyc;
    s1 = b + 2;
    bus.req = 4'b0010;
    push(s1, 4'b0010, 1, EV_LEN);
    push(s1 + SPACING, 4'b1000, 3, EV_LEN);
    push(s1 + 2 * SPACING, 4'b0001, 0, EV_LEN);
    s3 = s1 + 3 * SPACING;
    push(s3, 4'b0010, 1, EV_LEN);
    push(s3 + SPACING, 4'b0010, 1, EV_LEN);
    goto(b + 1);
    bus.req = 4'b0000;
    goto(b + 3);
    bus.req = 4'b1001;
    goto(s1 + EV_LEN + 1);
    bus.req = 4'b1011;
    goto(s3 + 2);
    bus.req = 4'b1001;
    goto(s3 + EV_LEN - 1);
    bus.req = 4'b1011;
    goto(s3 + SPACING + SPACING);
    bus.req = 4'b0000;

    // Dismiss in the second off half of source 0 while source 2 waits
    goto(s3 + 2 * SPACING + 2);
    b = cyc;
    s = b + 2;
    bus.req = 4'b0001;
    push(s, 4'b0001, 0, 14);
    push(s + 18, 4'b0100, 2, EV_LEN);
    goto(b + 3);
    bus.req = 4'b0100;
    goto(s + 13);
    bus.dismiss = 1'b1;
    goto(s + 14);
    bus.dismiss = 1'b0;
    bus.req = 4'b0000;

    // Reset during RING_ON: outputs clear at once and the event is lost
    goto(s + 18 + SPACING + 2);
    b  = cyc;
    s5 = b + 2;
    bus.req = 4'b0010;
    push(s5, 4'b0010, 1, -1);
    goto(s5);
    bus.req = 4'b0000;
    goto(s5 + 1);
    reset = 1'b1;
    #1;
    chk("midreset_ring", int'(bus.ring), 0);
    chk("midreset_active", int'(bus.active), 0);
    chk("midreset_grant", int'(bus.grant), 0);
    chk("midreset_owner", int'(bus.owner), 0);
    goto(s5 + 3);
    reset = 1'b0;
    r = cyc;

    // Quiet after reset; then last restarts at N_REQ-1 so source 1 beats source 2
    goto(r + 20);
    b = cyc;
    bus.req = 4'b0110;
    push(b + 2, 4'b0010, 1, EV_LEN);
    push(b + 2 + SPACING, 4'b0100, 2, EV_LEN);
    goto(b + 3);
    bus.req = 4'b0000;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    goto(b + 2 + SPACING + SPACING);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/suna_ctrl.md
# suna_ctrl

Alarm sequencer for the ring/LED path: collects alarm requests from several sources, arbitrates them round-robin, and for the granted source drives the `semnal`-style ring enable with a fixed on/off cadence for a bounded duration, then enforces a quiet gap before serving the next source. It sits between the timer/button logic and the LED ring output, and is the only block that drives ring enable.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TICK_DIV`, 25_000_000: clock cycles per half-period of the ring cadence (>=2).
- `RING_CYCLES`, 10: full on/off periods per ring event (>=1).
- `GAP_TICKS`, 50_000_000: quiet cycles after a ring event ends (>=1).

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req` in N_REQ: level alarm requests; a 0->1 edge registers one pending event.
- `dismiss` in 1: one-cycle pulse; ends the current ring event early.
- `ring` out 1: ring/LED enable, cadence waveform.
- `active` out 1: high while a ring event is in progress (RING_ON/RING_OFF).
- `grant` out N_REQ: one-hot owner of the current ring event; 0 otherwise.
- `owner` out clog2(N_REQ): index of last/current grant; holds its value outside events.

## Operation
- Edge detect: `req_q` registered copy; rise = `req & ~req_q`. `req_q` resets to 0, so a request held high through reset counts as one edge.
- `pending[i]` set on rise[i]; cleared when event i ends (timeout or dismiss). Set and clear in the same cycle: set wins.
- FSM states: IDLE, RING_ON, RING_OFF, COOLDOWN.
- IDLE: if `pending != 0`, pick winner round-robin starting at `(last+1) mod N_REQ`; register `grant`, `owner`, `last`; load counters; go RING_ON. Otherwise stay.
- RING_ON: `ring=1`; after TICK_DIV cycles -> RING_OFF.
- RING_OFF: `ring=0`; after TICK_DIV cycles: if RING_CYCLES periods done -> COOLDOWN (clear pending[owner]), else -> RING_ON.
- `dismiss` in RING_ON or RING_OFF: next state COOLDOWN, `ring` 0 the next cycle, clear pending[owner]. Ignored in IDLE/COOLDOWN.
- COOLDOWN: `ring=0`, `active=0`, `grant=0`; after GAP_TICKS cycles -> IDLE.
- Counters: half-period counter width clog2(TICK_DIV), period counter width clog2(RING_CYCLES+1), gap counter width clog2(GAP_TICKS+1); all reload on state entry, never wrap.

## Timing
- Reset values: `ring=0`, `active=0`, `grant=0`, `owner=0`, `last=N_REQ-1` (source 0 first), `pending=0`, state IDLE.
- Latency: rise sampled at edge k -> pending set at k -> grant/`ring=1`/`active=1` after edge k+1.
- Ring event: 2*TICK_DIV*RING_CYCLES cycles from first `ring=1` to `active` low; `ring` high exactly TICK_DIV cycles per period.
- Back-to-back events: gap between one event's last ring cycle and next `ring=1` = GAP_TICKS + 1 cycles (COOLDOWN + one IDLE arbitration cycle).
- All outputs registered; no combinational path from inputs to outputs.
- Reset asserted mid-event: outputs drop to reset values asynchronously; pending events are lost.

## Structure
- Package `suna_pkg`: state enum, default parameter constants.
- Sub-module `suna_rr_arbiter`: combinational round-robin pick (pending, last) -> one-hot winner + index + valid.
- Top holds edge detect, pending register, FSM, counters.

## Test plan
Params for bench: N_REQ=4, TICK_DIV=4, RING_CYCLES=2, GAP_TICKS=3.
- Single req[2] rise at cycle 10 -> `grant=4'b0100`, `owner=2`, `ring` high at 12-15, low 16-19, high 20-23, low 24-27; `active` low from 28; pending[2]=0.
- req[0] and req[3] high through reset release -> source 0 served first, `ring` for source 3 rises 16+3+1=20 cycles after source 0's first `ring`.
- After serving source 1, pending {0,1,3} -> order 3, 0, 1.
- `dismiss` during second RING_OFF of source 0 with req[2] pending -> `ring` stays 0, COOLDOWN 3 cycles, source 2 `ring` rises 4 cycles after dismiss cycle +1.
- `reset` pulse during RING_ON -> `ring`, `active`, `grant` 0 immediately; no ring after reset until a new rise.
- Owner re-raises its req on the cycle the event times out -> pending stays set (set wins), same source rings again after gap.
